// File: rtl/or_accum16_pkg.sv
// or_accum16_pkg
//   Shared definitions for the OR accumulator block: the controller state
//   encoding and the all-ones word used to flag a fully-set result.
//   No ports; imported by or_accum16.
package or_accum16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] ALL_ONES = 16'hFFFF;

endpackage

// File: rtl/or_accum16_or16.sv
// Or16
//   Plain 16-bit bitwise OR gate; the accumulator datapath of or_accum16.
//   Ports:
//     a  in  16  current accumulator value
//     b  in  16  incoming word
//     y  out 16  a | b
module Or16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a | b;

endmodule

// File: rtl/or_accum16.sv
// or_accum16
//   Collects a burst of 1..2^CNT_W 16-bit words, ORs them together and
//   presents the result with a valid/ready handshake. Zero and all-ones
//   flags are registered alongside the result.
//   Ports:
//     clock      in   1      rising-edge clock
//     reset      in   1      synchronous active-high reset
//     start      in   1      begin a burst (honoured only in IDLE)
//     len        in   CNT_W  burst length minus one, sampled with start
//     in_valid   in   1      upstream word valid
//     in_ready   out  1      high only while accumulating
//     in_data    in   16     word to OR in
//     out_valid  out  1      result available (DONE)
//     out_ready  in   1      downstream takes the result
//     out_data   out  16     OR of all burst words (held until next result)
//     out_zero   out  1      out_data == 0
//     out_all    out  1      out_data == 16'hFFFF
//     busy       out  1      controller not idle
module or_accum16
  import or_accum16_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_zero,
  output logic             out_all,
  output logic             busy
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      acc;
  logic [15:0]      acc_or;
  logic             xfer;
  logic             last;

  Or16 u_or16 (
    .a (acc),
    .b (in_data),
    .y (acc_or)
  );

  // Handshake-side outputs depend on state alone, never on inputs.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign xfer = in_ready && in_valid;
  // cnt holds words remaining after the current one, so zero marks the last.
  assign last = (cnt == '0);

  // Next-state logic. start is only looked at in IDLE, so a start coinciding
  // with the DONE handshake lands us in IDLE without beginning a burst.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)          state_nx = ACCUM;
      ACCUM:   if (xfer && last)   state_nx = DONE;
      DONE:    if (out_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // State, counter, accumulator and result registers. The result and its
  // flags are only written on the final transfer so they persist through
  // the handshake and the following idle period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_zero <= 1'b1;
      out_all  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cnt <= len;
        acc <= '0;
      end
      if (xfer) begin
        acc <= acc_or;
        if (!last) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          out_data <= acc_or;
          out_zero <= (acc_or == 16'h0000);
          out_all  <= (acc_or == ALL_ONES);
        end
      end
    end
  end

endmodule

// File: tb/tb_or_accum16.sv
// tb_or_accum16
//   Self-checking bench for or_accum16: directed bursts followed by random
//   bursts, each compared against the OR of the words the bench sent.
module tb_or_accum16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_all;
  logic        busy;

  int          tests    = 0;
  int          failures = 0;
  logic [15:0] expOr;

  or_accum16 #(.CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_all   (out_all),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result-side expectations follow directly from the OR of the burst words.
  task automatic checkResult(input string tag);
    checkOutput({tag, " out_data"}, 32'(out_data), 32'(expOr));
    checkOutput({tag, " out_zero"}, 32'(out_zero), 32'(expOr == 16'h0000));
    checkOutput({tag, " out_all"},  32'(out_all),  32'(expOr == 16'hFFFF));
  endtask

  // Idle cycle with junk on in_data / in_valid, then start a burst.
  task automatic applyStimulus(input logic [3:0] l, input string tag);
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    step();
    checkOutput({tag, " idle busy"}, 32'(busy), 0);
    in_valid = 1'b0;
    start    = 1'b1;
    len      = l;
    step();
    start    = 1'b0;
    len      = 4'($urandom);
    checkOutput({tag, " in_ready after start"}, 32'(in_ready), 1);
    checkOutput({tag, " busy after start"}, 32'(busy), 1);
  endtask

  // Feed the words with a random number of idle gaps before each; the
  // result must appear exactly one cycle after the last accepted word.
  task automatic sendWords(input logic [15:0] words[$], input int minGap,
                           input int maxGap, input string tag);
    expOr = 16'h0000;
    foreach (words[i]) begin
      int g;
      g = $urandom_range(maxGap, minGap);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        if ($urandom_range(1, 0) == 1) start = 1'b1;
        step();
        start = 1'b0;
      end
      checkOutput({tag, " in_ready"}, 32'(in_ready), 1);
      checkOutput({tag, " out_valid early"}, 32'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = words[i];
      step();
      expOr = expOr | words[i];
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 1);
    checkOutput({tag, " in_ready done"}, 32'(in_ready), 0);
    checkResult(tag);
  endtask

  // Stall in DONE for a while (with start noise), then hand off while start
  // is high; the block must go idle and stay idle.
  task automatic drainResult(input int stall, input string tag);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      start     = 1'($urandom);
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      step();
      checkOutput({tag, " stall out_valid"}, 32'(out_valid), 1);
      checkOutput({tag, " stall busy"}, 32'(busy), 1);
      checkResult({tag, " stall"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    checkOutput({tag, " post out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, " post busy"}, 32'(busy), 0);
    checkResult({tag, " retained"});
    step();
    checkOutput({tag, " start ignored"}, 32'(busy), 0);
    checkResult({tag, " retained2"});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] w;
    int          n;
    int          mode;

    reset     = 1'b1;
    start     = 1'b1;
    len       = 4'hF;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    expOr = 16'h0000;
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset in_ready", 32'(in_ready), 0);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkResult("reset");

    // Single-word burst.
    applyStimulus(4'd0, "len0");
    q = {16'h00F0};
    sendWords(q, 0, 0, "len0");
    drainResult(0, "len0");

    // Four words with forced gaps.
    applyStimulus(4'd3, "len3");
    q = {16'h0001, 16'h0010, 16'h0100, 16'h1000};
    sendWords(q, 1, 3, "len3");
    checkOutput("len3 value", 32'(out_data), 32'h1111);
    drainResult(1, "len3");

    // Maximum-length burst of single-bit words.
    applyStimulus(4'd15, "len15");
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'(1 << i));
    sendWords(q, 0, 2, "len15");
    checkOutput("len15 all", 32'(out_all), 1);
    drainResult(5, "len15");

    // Reset in the middle of a burst discards it.
    applyStimulus(4'd3, "rst");
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    step();
    in_data  = 16'h0F0F;
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    expOr    = 16'h0000;
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst out_valid", 32'(out_valid), 0);
    checkOutput("rst in_ready", 32'(in_ready), 0);
    checkResult("rst");
    applyStimulus(4'd0, "rst zero");
    q = {16'h0000};
    sendWords(q, 0, 1, "rst zero");
    checkOutput("rst zero flag", 32'(out_zero), 1);
    drainResult(2, "rst zero");

    // Random bursts: dense, sparse, all-zero or single-bit mixes.
    for (int b = 0; b < 24; b++) begin
      n    = $urandom_range(16, 1);
      mode = $urandom_range(3, 0);
      q    = {};
      for (int i = 0; i < n; i++) begin
        case (mode)
          0:       w = 16'($urandom);
          1:       w = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2:       w = 16'h0000;
          default: w = 16'(1 << $urandom_range(15, 0));
        endcase
        q.push_back(w);
      end
      applyStimulus(4'(n - 1), "rand");
      sendWords(q, 0, 3, "rand");
      drainResult($urandom_range(3, 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/or_accum16.md
OR_ACCUM16 -- requirements
Module: or_accum16

Interface
REQ-001 SHALL have parameter: CNT_W, default 4, width of the burst-length field (bursts of 1..2^CNT_W words).
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  begin a burst; sampled only in IDLE.
REQ-005 SHALL have port: len  input  CNT_W  burst length minus one; sampled with start.
REQ-006 SHALL have port: in_valid  input  1  upstream word valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port: in_data  input  16  word to OR into the accumulator.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  downstream consumes the result.
REQ-011 SHALL have port: out_data  output  16  bitwise OR of all burst words.
REQ-012 SHALL have port: out_zero  output  1  out_data == 16'h0000.
REQ-013 SHALL have port: out_all  output  1  out_data == 16'hFFFF.
REQ-014 SHALL have port: busy  output  1  state is not IDLE.

Function
REQ-015 SHALL implement three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE with start=1, SHALL load the remaining-count register from len, clear the accumulator to 16'h0000, and enter ACCUM on the next edge.
REQ-017 SHALL ignore start in ACCUM and DONE, with no effect on state, count or accumulator.
REQ-018 SHALL drive in_ready = 1 only in ACCUM, as a pure function of state.
REQ-019 A transfer SHALL occur on an edge where in_valid=1 and in_ready=1: acc <= acc | in_data.
REQ-020 On a transfer with remaining count nonzero, SHALL decrement the count and stay in ACCUM.
REQ-021 On a transfer with remaining count zero, SHALL enter DONE and register out_data <= acc | in_data; out_valid rises the next cycle (1-cycle latency from the last word).
REQ-022 In ACCUM with in_valid=0, SHALL change no state.
REQ-023 In DONE, SHALL drive out_valid = 1 and hold out_data, out_zero and out_all stable until out_ready = 1.
REQ-024 In DONE with out_ready=1, SHALL return to IDLE; out_valid = 0 from the next cycle.
REQ-025 A start asserted in the same cycle as the DONE-to-IDLE handshake SHALL be ignored; a new burst requires start while in IDLE.
REQ-026 After a completed handshake, out_data, out_zero and out_all SHALL retain the last result until the next DONE.
REQ-027 len = 0 SHALL mean a one-word burst; len = 2^CNT_W-1 SHALL mean a 2^CNT_W-word burst with no count wrap-around.
REQ-028 out_zero and out_all SHALL be registered together with out_data and never be combinational from in_data.
REQ-029 in_data SHALL have no effect outside an accepted transfer.

Reset
REQ-030 reset SHALL take effect at the next rising clock edge and override all other inputs.
REQ-031 On reset, state SHALL become IDLE and the accumulator, count and out_data SHALL be 0.
REQ-032 On reset, out_valid, in_ready and busy SHALL be 0, out_zero SHALL be 1 and out_all SHALL be 0.
REQ-033 Reset asserted mid-burst (ACCUM or DONE) SHALL discard the partial result with no output handshake.

Structure
REQ-034 State encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the all-ones constant 16'hFFFF SHALL live in a shared header included by this block.
REQ-035 The OR datapath SHALL be one instance of the existing 16-bit gate module Or16 (acc, in_data -> next acc); no other sub-module.

Verification
REQ-036 Reset then start, len=0, one word 16'h00F0 -> in_ready high one cycle after start; out_valid next cycle after the transfer; out_data=16'h00F0, out_zero=0, out_all=0.
REQ-037 len=3, words 16'h0001, 16'h0010, 16'h0100, 16'h1000 with in_valid gaps -> out_data=16'h1111; count unaffected by gap cycles.
REQ-038 len=15, sixteen words each with a distinct single bit set -> out_data=16'hFFFF, out_all=1; exactly 16 transfers accepted.
REQ-039 Result in DONE with out_ready held 0 for 5 cycles, start pulsed -> outputs stable, state stays DONE, start ignored; out_ready=1 -> IDLE.
REQ-040 reset asserted after 2 of 4 words -> next cycle IDLE, out_valid=0, out_data=0; a following len=0 burst with 16'h0000 -> out_zero=1.
